ripple_carry_adder: RTL and testbench

Parameterized N-bit ripple-carry adder computing {Cout, Sum} = A + B + Cin through a chain of single-bit full adders, with a combinational result path and a one-cycle registered copy of the result. It is a datapath leaf used wherever an unsigned add with carry-in/carry-out is needed. The combinational outputs are the primary contract. The registered outputs let pipelined consumers take the result without extra glue.

---
 rtl/ripple_carry_adder.sv | 55 +++++
 tb/tb_ripple_carry_adder.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ripple_carry_adder.sv
// N-bit ripple-carry adder: combinational {Cout, Sum} = A + B + Cin through a chain of full adders,
// plus a one-cycle registered copy of the result with a two's-complement overflow flag.
module ripple_carry_adder #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    input  logic         in_valid,
    output logic [N-1:0] Sum,
    output logic         Cout,
    output logic [N-1:0] Sum_q,
    output logic         Cout_q,
    output logic         Ovf_q,
    output logic         out_valid
);

    // carry[i] is the carry into bit i; carry[N] is the carry out of the MSB.
    logic [N:0] carry;
    logic       ovf;

    assign carry[0] = Cin;

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_stage
            assign Sum[i]       = A[i] ^ B[i] ^ carry[i];
            assign carry[i+1]   = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
        end
    endgenerate

    assign Cout = carry[N];

    // Signed overflow: carry into and out of the sign bit disagree (for N = 1 this is Cout ^ Cin).
    assign ovf = carry[N] ^ carry[N-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Sum_q     <= '0;
            Cout_q    <= 1'b0;
            Ovf_q     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                Sum_q  <= Sum;
                Cout_q <= Cout;
                Ovf_q  <= ovf;
            end
        end
    end

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Directed and random checks for ripple_carry_adder (N=8): combinational sum/carry,
// registered capture/hold, overflow flag and asynchronous reset.
module tb_ripple_carry_adder;

    logic       clk;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       in_valid;
    logic [7:0] sum;
    logic       cout;
    logic [7:0] sum_q;
    logic       cout_q;
    logic       ovf_q;
    logic       out_valid;

    int compare_count;
    int mismatch_count;

    ripple_carry_adder #(.N(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (a),
        .B         (b),
        .Cin       (cin),
        .in_valid  (in_valid),
        .Sum       (sum),
        .Cout      (cout),
        .Sum_q     (sum_q),
        .Cout_q    (cout_q),
        .Ovf_q     (ovf_q),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [8:0] actual, input logic [8:0] expected);
        compare_count++;
        if (actual !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drives operands and lets the combinational path settle for 5 ns.
    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic cv, input logic vv);
        a        = av;
        b        = bv;
        cin      = cv;
        in_valid = vv;
        #5;
    endtask

    initial begin
        logic [8:0] expected;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;

        compare_count  = 0;
        mismatch_count = 0;
        rst      = 1'b1;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        in_valid = 1'b0;

        #3;
        checkOutput("reset_sum_q",     {1'b0, sum_q},     9'h000);
        checkOutput("reset_cout_q",    {8'h00, cout_q},   9'h000);
        checkOutput("reset_ovf_q",     {8'h00, ovf_q},    9'h000);
        checkOutput("reset_out_valid", {8'h00, out_valid}, 9'h000);

        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
        checkOutput("comb_zero", {cout, sum}, 9'h000);
        applyStimulus(8'h05, 8'h0A, 1'b0, 1'b0);
        checkOutput("comb_5_plus_10", {cout, sum}, 9'h00F);
        applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0);
        checkOutput("comb_wrap", {cout, sum}, 9'h100);
        applyStimulus(8'hAA, 8'h55, 1'b1, 1'b0);
        checkOutput("comb_full_ripple", {cout, sum}, 9'h100);
        applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b0);
        checkOutput("comb_all_ones_cin", {cout, sum}, 9'h1FF);
        applyStimulus(8'h00, 8'h00, 1'b1, 1'b0);
        checkOutput("comb_cin_only", {cout, sum}, 9'h001);
        applyStimulus(8'h80, 8'h80, 1'b0, 1'b0);
        checkOutput("comb_msb_carry", {cout, sum}, 9'h100);

        // Random vectors: stop at the first mismatch but still reach the summary.
        for (int k = 0; k < 50; k++) begin
            ra = 8'($urandom());
            rb = 8'($urandom());
            rc = 1'($urandom());
            expected = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
            applyStimulus(ra, rb, rc, 1'b0);
            if ({cout, sum} !== expected) begin
                $display("[TB] A=0x%0h B=0x%0h Cin=%0b", ra, rb, rc);
                checkOutput("comb_random", {cout, sum}, expected);
                break;
            end
            compare_count++;
        end

        @(negedge clk);
        rst = 1'b0;
        applyStimulus(8'h7F, 8'h01, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("reg_sum_q_7f",     {1'b0, sum_q},     9'h080);
        checkOutput("reg_cout_q_7f",    {8'h00, cout_q},   9'h000);
        checkOutput("reg_ovf_q_7f",     {8'h00, ovf_q},    9'h001);
        checkOutput("reg_out_valid_7f", {8'h00, out_valid}, 9'h001);

        @(negedge clk);
        applyStimulus(8'h12, 8'h34, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("hold_sum_q",     {1'b0, sum_q},     9'h080);
        checkOutput("hold_ovf_q",     {8'h00, ovf_q},    9'h001);
        checkOutput("hold_out_valid", {8'h00, out_valid}, 9'h000);

        @(negedge clk);
        applyStimulus(8'hFF, 8'h01, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("reg_sum_q_wrap",  {1'b0, sum_q},   9'h000);
        checkOutput("reg_cout_q_wrap", {8'h00, cout_q}, 9'h001);
        checkOutput("reg_ovf_q_wrap",  {8'h00, ovf_q},  9'h000);

        @(negedge clk);
        applyStimulus(8'h80, 8'h80, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("reg_sum_q_neg",  {1'b0, sum_q},   9'h000);
        checkOutput("reg_cout_q_neg", {8'h00, cout_q}, 9'h001);
        checkOutput("reg_ovf_q_neg",  {8'h00, ovf_q},  9'h001);

        @(negedge clk);
        applyStimulus(8'h3C, 8'h0F, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("reg_sum_q_cin", {1'b0, sum_q}, 9'h04C);

        // Reset between edges must clear the registered stage without a clock.
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_sum_q",     {1'b0, sum_q},     9'h000);
        checkOutput("async_rst_cout_q",    {8'h00, cout_q},   9'h000);
        checkOutput("async_rst_ovf_q",     {8'h00, ovf_q},    9'h000);
        checkOutput("async_rst_out_valid", {8'h00, out_valid}, 9'h000);

        @(posedge clk);
        #1;
        checkOutput("rst_held_sum_q",     {1'b0, sum_q},     9'h000);
        checkOutput("rst_held_out_valid", {8'h00, out_valid}, 9'h000);

        @(negedge clk);
        rst = 1'b0;
        applyStimulus(8'h40, 8'h40, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("post_rst_sum_q",     {1'b0, sum_q},     9'h080);
        checkOutput("post_rst_ovf_q",     {8'h00, ovf_q},    9'h001);
        checkOutput("post_rst_out_valid", {8'h00, out_valid}, 9'h001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
